// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and consumer handshake for uart_rx.
// The master modport is the line/consumer side; slave is the receiver.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, qualifies the start bit, samples mid-bit, holds a sticky rdy.
// Optional stop-bit check enabled by defining UART_RX_FRAME_ERR_EN (frm_err tied 0 otherwise).
module uart_rx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(9);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_e;

    logic       rx_m_q;
    logic       rx_s_q;
    logic       rx_d_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       fall_c;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q, rdy_d;
    logic             start_c;
    logic             done_c;

    // Edges are only trusted once rx_s reflects the live line and has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            rx_m_q <= bus.RX;
            rx_s_q <= rx_m_q;
            rx_d_q <= rx_s_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if (fill_q == 2'd2 && rx_s_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall_c = armed_q & rx_d_q & ~rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
        end
    end

    // Next-state: start detect, mid-bit sampling, byte delivery; a set of rdy overrides clr_rdy.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        start_c   = 1'b0;
        done_c    = 1'b0;

        if (bus.clr_rdy) begin
            rdy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    state_d = ST_RECV;
                    baud_d  = HALF_LD;
                    bit_d   = '0;
                    rdy_d   = 1'b0;
                    start_c = 1'b1;
                end
            end
            ST_RECV: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CNT_W'(1);
                end else begin
                    baud_d = FULL_LD;
                    bit_d  = bit_q + BIT_W'(1);
                    if (bit_q == '0) begin
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end
                    end else if (bit_q == STOP_IDX) begin
                        rx_data_d = shreg_q;
                        rdy_d     = 1'b1;
                        done_c    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;

`ifdef UART_RX_FRAME_ERR_EN
    logic frm_err_q;

    // Follows rdy: captured with the byte, cleared by the consumer or the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else if (done_c) begin
            frm_err_q <= ~rx_s_q;
        end else if (bus.clr_rdy || start_c) begin
            frm_err_q <= 1'b0;
        end
    end

    assign bus.frm_err = frm_err_q;
`else
    assign bus.frm_err = 1'b0;
`endif

endmodule
